// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nic_pkg
// Description : NIC register-port addresses and host-agent FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nic_pkg;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OST_RD  = 3'd1,
        ST_OST_CHK = 3'd2,
        ST_OUT_WR  = 3'd3,
        ST_IST_RD  = 3'd4,
        ST_IST_CHK = 3'd5,
        ST_IN_RD   = 3'd6,
        ST_IN_CAP  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nic_host_agent.sv
`default_nettype none
// ============================================================================
// Module      : nic_host_agent
// Description : Host-side initiator for one NIC register port; moves TX packets
//               into the NIC output buffer and RX packets out to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module nic_host_agent
    import nic_pkg::*;
#(
    parameter int DW       = 64,
    parameter int CNT_W    = 16,
    parameter int STAT_BIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    input  logic [DW-1:0]    tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [DW-1:0]    rx_data,
    input  logic             rx_ready,
    output logic [1:0]       nic_addr,
    output logic [DW-1:0]    nic_do,
    input  logic [DW-1:0]    nic_di,
    output logic             nic_en,
    output logic             nic_wr_en,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic             r_tx_full;
    logic             r_tx_rdy;
    logic             r_rx_valid;
    logic             r_last_tx;
    logic [DW-1:0]    r_tx_buf;
    logic [DW-1:0]    r_rx_data;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] r_rx_cnt;

    logic             w_en;
    logic             w_wr;
    logic [1:0]       w_addr;
    logic [DW-1:0]    w_do;
    logic             w_tx_hs;
    logic             w_rx_hs;
    logic             w_tx_cand;
    logic             w_rx_cand;
    logic             w_stat;

    assign w_tx_hs   = tx_valid && tx_ready;
    assign w_rx_hs   = r_rx_valid && rx_ready;
    assign w_tx_cand = r_tx_full;
    // The RX slot counts as free in the cycle the host drains it.
    assign w_rx_cand = !r_rx_valid || rx_ready;
    assign w_stat    = nic_di[STAT_BIT];

    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        w_wr   = 1'b0;
        w_addr = ADDR_IN_BUF;
        w_do   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_tx_cand && (!w_rx_cand || !r_last_tx))
                    w_next = ST_OST_RD;
                else if (w_rx_cand)
                    w_next = ST_IST_RD;
            end
            ST_OST_RD: begin
                w_en   = 1'b1;
                w_addr = ADDR_OUT_STAT;
                w_next = ST_OST_CHK;
            end
            ST_OST_CHK: w_next = w_stat ? ST_IDLE : ST_OUT_WR;
            ST_OUT_WR: begin
                w_en   = 1'b1;
                w_wr   = 1'b1;
                w_addr = ADDR_OUT_BUF;
                w_do   = r_tx_buf;
                w_next = ST_IDLE;
            end
            ST_IST_RD: begin
                w_en   = 1'b1;
                w_addr = ADDR_IN_STAT;
                w_next = ST_IST_CHK;
            end
            ST_IST_CHK: w_next = w_stat ? ST_IN_RD : ST_IDLE;
            ST_IN_RD: begin
                w_en   = 1'b1;
                w_addr = ADDR_IN_BUF;
                w_next = ST_IN_CAP;
            end
            ST_IN_CAP: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_full  <= 1'b0;
            r_tx_rdy   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_last_tx  <= 1'b0;
            r_tx_buf   <= '0;
            r_rx_data  <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
        end else begin
            r_state  <= w_next;
            r_tx_rdy <= 1'b1;

            if (w_tx_hs) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end else if (r_state == ST_OUT_WR) begin
                r_tx_full <= 1'b0;
                r_tx_cnt  <= r_tx_cnt + CNT_W'(1);
            end

            if (r_state == ST_IN_CAP) begin
                r_rx_data  <= nic_di;
                r_rx_valid <= 1'b1;
                r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
            end else if (w_rx_hs) begin
                r_rx_valid <= 1'b0;
            end

            // Remember which side was granted so the other wins the next tie.
            if (r_state == ST_IDLE && w_next == ST_OST_RD)
                r_last_tx <= 1'b1;
            else if (r_state == ST_IDLE && w_next == ST_IST_RD)
                r_last_tx <= 1'b0;
        end
    end

    // NIC strobes are suppressed while reset is held so an interrupted access
    // never reaches the NIC.
    assign nic_en    = w_en && !reset;
    assign nic_wr_en = w_wr && !reset;
    assign nic_addr  = reset ? ADDR_IN_BUF : w_addr;
    assign nic_do    = reset ? '0 : w_do;

    assign tx_ready  = r_tx_rdy && !r_tx_full;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign tx_cnt    = r_tx_cnt;
    assign rx_cnt    = r_rx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nic_host_agent.sv
`default_nettype none
// ============================================================================
// Module      : tb_nic_host_agent
// Description : Self-checking bench with a behavioural NIC register port and
//               TX/RX scoreboards for nic_host_agent.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nic_host_agent;
    import nic_pkg::*;

    localparam int DW    = 64;
    localparam int CNT_W = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             tx_valid = 1'b0;
    logic [DW-1:0]    tx_data  = '0;
    logic             rx_ready = 1'b0;
    logic [DW-1:0]    nic_di   = '0;
    logic             tx_ready;
    logic             rx_valid;
    logic [DW-1:0]    rx_data;
    logic [1:0]       nic_addr;
    logic [DW-1:0]    nic_do;
    logic             nic_en;
    logic             nic_wr_en;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] tx_exp[$];
    logic [DW-1:0] rx_exp[$];
    logic [DW-1:0] in_q[$];
    logic [1:0]    poll_log[$];
    logic          out_full = 1'b0;
    int            n_writes = 0;
    int            n_ost    = 0;
    int            n_ist    = 0;
    int            last_ost_cyc = 0;
    int            last_wr_cyc  = 0;
    logic [DW-1:0] mon_e;

    nic_host_agent #(.DW(DW), .CNT_W(CNT_W), .STAT_BIT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .nic_addr  (nic_addr),
        .nic_do    (nic_do),
        .nic_di    (nic_di),
        .nic_en    (nic_en),
        .nic_wr_en (nic_wr_en),
        .tx_cnt    (tx_cnt),
        .rx_cnt    (rx_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NIC register port model and both scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        if (nic_en === 1'b1) begin
            if (nic_wr_en === 1'b1) begin
                n_writes++;
                last_wr_cyc = cyc;
                checks++;
                if (nic_addr !== ADDR_OUT_BUF) begin
                    errors++;
                    $display("FAIL nic_wr_addr: got %b required %b", nic_addr, ADDR_OUT_BUF);
                end
                checks++;
                if (tx_exp.size() == 0) begin
                    errors++;
                    $display("FAIL nic_wr_data: got %h with no packet outstanding", nic_do);
                end else begin
                    mon_e = tx_exp.pop_front();
                    if (nic_do !== mon_e) begin
                        errors++;
                        $display("FAIL nic_wr_data: got %h required %h", nic_do, mon_e);
                    end
                end
            end else begin
                case (nic_addr)
                    ADDR_IN_BUF:   nic_di = (in_q.size() > 0) ? in_q.pop_front() : '0;
                    ADDR_IN_STAT: begin
                        n_ist++;
                        poll_log.push_back(nic_addr);
                        nic_di = {8'hFF, 55'd0, in_q.size() != 0};
                    end
                    ADDR_OUT_STAT: begin
                        n_ost++;
                        last_ost_cyc = cyc;
                        poll_log.push_back(nic_addr);
                        nic_di = {8'hFF, 55'd0, out_full};
                    end
                    default: begin
                        checks++;
                        errors++;
                        $display("FAIL nic_rd_addr: got %b required not %b", nic_addr, ADDR_OUT_BUF);
                    end
                endcase
            end
        end else begin
            checks++;
            if (nic_addr !== 2'b00 || nic_do !== '0) begin
                errors++;
                $display("FAIL nic_idle: addr=%b do=%h required 00 and 0", nic_addr, nic_do);
            end
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            checks++;
            if (rx_exp.size() == 0) begin
                errors++;
                $display("FAIL rx_data: got %h with no packet outstanding", rx_data);
            end else begin
                mon_e = rx_exp.pop_front();
                if (rx_data !== mon_e) begin
                    errors++;
                    $display("FAIL rx_data: got %h required %h", rx_data, mon_e);
                end
            end
        end
    end

    task automatic send_tx(input logic [DW-1:0] d);
        int t = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tx_handshake: tx_ready=%b required 1 within 200 cycles", tx_ready);
        end else begin
            tx_exp.push_back(d);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string nm);
        int t = 0;
        while (n_writes < target && t < budget) begin
            t++;
            @(negedge clk);
        end
        if (n_writes < target) begin
            checks++;
            errors++;
            $display("FAIL %s: writes=%0d required %0d within %0d cycles", nm, n_writes, target, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_ready, rx_valid, nic_en, nic_wr_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: tx_ready/rx_valid/nic_en/wr_en=%b required 0000",
                     {tx_ready, rx_valid, nic_en, nic_wr_en});
        end
        checks++;
        if (tx_cnt !== '0 || rx_cnt !== '0 || rx_data !== '0) begin
            errors++;
            $display("FAIL reset_data: tx_cnt=%0d rx_cnt=%0d rx_data=%h required 0", tx_cnt, rx_cnt, rx_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tx_ready=%b required 1", tx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tx_basic();
        int w0 = n_writes;
        out_full = 1'b0;
        send_tx(64'hA5A5_0000_0000_0001);
        wait_writes(w0 + 1, 50, "tx_basic_wait");
        checks++;
        if (last_wr_cyc - last_ost_cyc != 2) begin
            errors++;
            $display("FAIL tx_latency: write %0d cycles after status read, required 2",
                     last_wr_cyc - last_ost_cyc);
        end
        @(negedge clk);
        checks++;
        if (tx_cnt !== 4'd1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_basic_cnt: tx_cnt=%0d tx_ready=%b required 1 and 1", tx_cnt, tx_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tx_backpressure();
        int w0 = n_writes;
        int o0 = n_ost;
        int t  = 0;
        out_full = 1'b1;
        send_tx(64'h0BAD_F00D_0000_0002);
        while (n_ost < o0 + 5 && t < 300) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (n_ost < o0 + 5 || n_writes != w0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_busy: polls=%0d writes=%0d tx_ready=%b required >=5, %0d, 0",
                     n_ost - o0, n_writes, tx_ready, w0);
        end
        @(posedge clk);
        #1;
        out_full = 1'b0;
        wait_writes(w0 + 1, 50, "tx_release_wait");
        repeat (6) @(negedge clk);
        checks++;
        if (n_writes != w0 + 1 || tx_ready !== 1'b1 || tx_cnt !== 4'd2) begin
            errors++;
            $display("FAIL tx_release: writes=%0d tx_ready=%b tx_cnt=%0d required %0d, 1, 2",
                     n_writes, tx_ready, tx_cnt, w0 + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rx_hold();
        logic [DW-1:0] d = 64'hDEAD_BEEF_0000_0042;
        int t  = 0;
        int i0;
        rx_ready = 1'b0;
        in_q.push_back(d);
        rx_exp.push_back(d);
        @(negedge clk);
        while (rx_valid !== 1'b1 && t < 50) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== d) begin
            errors++;
            $display("FAIL rx_capture: valid=%b data=%h required 1 and %h", rx_valid, rx_data, d);
        end
        i0 = n_ist;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== d || n_ist != i0) begin
            errors++;
            $display("FAIL rx_hold: valid=%b data=%h new_polls=%0d required 1, %h, 0",
                     rx_valid, rx_data, n_ist - i0, d);
        end
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        t = 0;
        while (rx_exp.size() != 0 && t < 20) begin
            t++;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (rx_exp.size() != 0 || rx_valid !== 1'b0 || rx_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rx_drain: pending=%0d valid=%b rx_cnt=%0d required 0, 0, 1",
                     rx_exp.size(), rx_valid, rx_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        int w0 = n_writes;
        int p0 = poll_log.size();
        int t  = 0;
        int j;
        int bad = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_q.push_back(64'h5500_0000_0000_0000 | 64'(i));
            rx_exp.push_back(64'h5500_0000_0000_0000 | 64'(i));
        end
        for (int i = 0; i < 4; i++)
            send_tx(64'h7700_0000_0000_0000 | 64'(i));
        wait_writes(w0 + 4, 100, "contention_wait");
        while (rx_exp.size() != 0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        j = p0;
        while (j < poll_log.size() && poll_log[j] != ADDR_OUT_STAT) j++;
        checks++;
        if (j + 7 > poll_log.size()) begin
            errors++;
            $display("FAIL contention_log: %0d polls after first tx poll, required 7", poll_log.size() - j);
        end else begin
            for (int k = 0; k < 6; k++)
                if (poll_log[j+k] == poll_log[j+k+1]) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL contention_order: %0d repeated grants, required 0", bad);
            end
        end
        checks++;
        if (rx_exp.size() != 0 || tx_exp.size() != 0) begin
            errors++;
            $display("FAIL contention_drain: rx pending=%0d tx pending=%0d required 0 and 0",
                     rx_exp.size(), tx_exp.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int w0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_cnt !== '0) begin
            errors++;
            $display("FAIL wrap_reset: tx_cnt=%0d required 0", tx_cnt);
        end
        @(posedge clk);
        #1;
        w0 = n_writes;
        for (int i = 0; i < 15; i++)
            send_tx(64'h3300_0000_0000_0000 | 64'(i));
        wait_writes(w0 + 15, 100, "wrap_wait15");
        @(negedge clk);
        checks++;
        if (tx_cnt !== 4'd15) begin
            errors++;
            $display("FAIL wrap_15: tx_cnt=%0d required 15", tx_cnt);
        end
        @(posedge clk);
        #1;
        send_tx(64'h3300_0000_0000_00FF);
        wait_writes(w0 + 16, 100, "wrap_wait16");
        @(negedge clk);
        checks++;
        if (tx_cnt !== 4'd0) begin
            errors++;
            $display("FAIL wrap_16: tx_cnt=%0d required 0", tx_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int t = 0;
        rx_ready = 1'b1;
        in_q.push_back(64'h1111_2222_3333_4444);
        rx_exp.push_back(64'h1111_2222_3333_4444);
        while (rx_exp.size() != 0 && t < 50) begin
            t++;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (rx_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mid_pre: rx_cnt=%0d required 1", rx_cnt);
        end
        in_q.push_back(64'h9999_8888_7777_6666);
        t = 0;
        @(negedge clk);
        while (!(nic_en === 1'b1 && nic_wr_en === 1'b0 && nic_addr == ADDR_IN_BUF) && t < 50) begin
            t++;
            @(negedge clk);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (t >= 50 || rx_valid !== 1'b0 || nic_en !== 1'b0 || rx_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: waited=%0d rx_valid=%b nic_en=%b rx_cnt=%0d required <50, 0, 0, 0",
                     t, rx_valid, nic_en, rx_cnt);
        end
        in_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || rx_cnt !== 4'd0 || tx_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_after: rx_valid=%b rx_cnt=%0d tx_cnt=%0d required 0, 0, 0",
                     rx_valid, rx_cnt, tx_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_backpressure();
        test_rx_hold();
        test_contention();
        test_wrap();
        test_reset_mid_op();
        checks++;
        if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
            errors++;
            $display("FAIL final_drain: tx pending=%0d rx pending=%0d required 0 and 0",
                     tx_exp.size(), rx_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
